// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg -- shared definitions for the Tomasulo result-broadcast path.
//   TAG_W_DEFAULT  : default reservation-station tag width
//   DATA_W_DEFAULT : default result value width
//   INVALID_TAG    : reserved tag meaning "no producer"; never broadcast
//   cdb_state_e    : common-data-bus arbiter state encoding
package tomasulo_pkg;

  localparam int TAG_W_DEFAULT  = 5;
  localparam int DATA_W_DEFAULT = 32;

  localparam logic [4:0] INVALID_TAG = 5'b11111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BCAST = 1'b1
  } cdb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- rotating-priority picker.
//   Scans the request vector starting at index 'base' and wrapping, and
//   returns a one-hot grant for the first set bit (all-zero if none).
// Ports:
//   req   [N-1:0]     : request vector
//   base  [IDX_W-1:0] : index holding highest priority
//   grant [N-1:0]     : one-hot-or-zero grant
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic [N-1:0]     grant
);

  logic found_s;

  // first requester at or after base (mod N) wins
  always_comb begin
    int idx;
    logic take;
    grant   = '0;
    found_s = 1'b0;
    idx     = 0;
    take    = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx        = (int'(base) + k) % N;
      take       = !found_s && req[idx];
      grant[idx] = grant[idx] | take;
      found_s    = found_s | take;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- common data bus arbiter.
//   Picks one functional-unit result per opportunity, latches it and drives
//   a one-cycle broadcast strobe; a mandatory idle cycle follows each strobe.
//   Build option: define CDB_ARB_ROUND_ROBIN_EN for rotating priority;
//   otherwise priority is fixed with unit 0 highest.
// Ports:
//   clk, rst (sync, active-high)
//   req_valid/req_tag/req_val : per-unit results, unit i in slice i
//   req_grant                 : combinational one-hot-or-zero acceptance
//   in_flush                  : squash pending broadcast, block grants
//   out_CDB_broadcast/_tag/_val : registered broadcast
//   out_bcast_count           : registered, wrapping broadcast count
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = TAG_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  output logic [NUM_REQ-1:0]        req_grant,
  input  logic                      in_flush,
  output logic                      out_CDB_broadcast,
  output logic [TAG_W-1:0]          out_CDB_tag,
  output logic [DATA_W-1:0]         out_CDB_val,
  output logic [15:0]               out_bcast_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // package value at the default width, all-ones otherwise
  localparam logic [TAG_W-1:0] INV_TAG =
    (TAG_W == 5) ? TAG_W'(INVALID_TAG) : {TAG_W{1'b1}};

  cdb_state_e          state_r, state_nxt_s;
  logic                bcast_r, bcast_nxt_s;
  logic [TAG_W-1:0]    tag_r, tag_nxt_s;
  logic [DATA_W-1:0]   val_r, val_nxt_s;
  logic [15:0]         count_r, count_nxt_s;
  logic [NUM_REQ-1:0]  pick_grant_s, grant_s;
  logic [IDX_W-1:0]    base_s;
  logic                accept_s;
  logic [TAG_W-1:0]    sel_tag_s;
  logic [DATA_W-1:0]   sel_val_s;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req_valid),
    .base  (base_s),
    .grant (pick_grant_s)
  );

  // grants only while idle and not squashed
  assign grant_s   = (state_r == ST_IDLE && !in_flush) ? pick_grant_s : '0;
  assign accept_s  = |grant_s;
  assign req_grant = grant_s;

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s, grant_idx_s;

  // encode the one-hot grant into an index
  always_comb begin
    grant_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx_s = grant_idx_s | (grant_s[i] ? IDX_W'(i) : '0);
    end
  end

  // pointer moves past the winner only on an accepting edge
  always_comb begin
    if (accept_s) begin
      ptr_nxt_s = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign base_s = ptr_r;
`else
  assign base_s = '0;
`endif

  // select the winning tag/value (grant is one-hot or zero)
  always_comb begin
    sel_tag_s = '0;
    sel_val_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_tag_s = sel_tag_s | (req_tag[i*TAG_W +: TAG_W] & {TAG_W{grant_s[i]}});
      sel_val_s = sel_val_s | (req_val[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_nxt_s = state_r;
    bcast_nxt_s = 1'b0;
    tag_nxt_s   = tag_r;
    val_nxt_s   = val_r;
    count_nxt_s = count_r;
    if (in_flush) begin
      state_nxt_s = ST_IDLE;
      tag_nxt_s   = INV_TAG;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // an invalid-tag request is consumed silently
          if (accept_s && (sel_tag_s != INV_TAG)) begin
            state_nxt_s = ST_BCAST;
            bcast_nxt_s = 1'b1;
            tag_nxt_s   = sel_tag_s;
            val_nxt_s   = sel_val_s;
            count_nxt_s = count_r + 16'd1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BCAST: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      bcast_r <= 1'b0;
      tag_r   <= INV_TAG;
      val_r   <= '0;
      count_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      bcast_r <= bcast_nxt_s;
      tag_r   <= tag_nxt_s;
      val_r   <= val_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign out_CDB_broadcast = bcast_r;
  assign out_CDB_tag       = tag_r;
  assign out_CDB_val       = val_r;
  assign out_bcast_count   = count_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter -- scoreboard bench for cdb_arbiter.
//   Requesters are modelled as pending slots that hold until granted (or
//   drop at random). A reference model predicts grants and queues expected
//   broadcasts; a monitor compares the registered outputs every cycle.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam logic [TW-1:0] INV = 5'b11111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_val = '0;
  logic [N-1:0]    req_grant;
  logic            out_CDB_broadcast;
  logic [TW-1:0]   out_CDB_tag;
  logic [DW-1:0]   out_CDB_val;
  logic [15:0]     out_bcast_count;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_tag           (req_tag),
    .req_val           (req_val),
    .req_grant         (req_grant),
    .in_flush          (in_flush),
    .out_CDB_broadcast (out_CDB_broadcast),
    .out_CDB_tag       (out_CDB_tag),
    .out_CDB_val       (out_CDB_val),
    .out_bcast_count   (out_bcast_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // requester slots
  bit            pend [N];
  logic [TW-1:0] ptag [N];
  logic [DW-1:0] pval [N];

  // reference model
  bit            m_busy = 1'b0;
  int            m_ptr  = 0;
  logic [15:0]   m_cnt  = 16'd0;
  logic [TW-1:0] m_tag  = INV;
  logic [DW-1:0] m_val  = '0;
  int            grant_hist [N];

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] val;
    logic [15:0]   cnt;
  } bc_t;
  bc_t exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // index of the winning pending requester, -1 if none
  function automatic int pick();
    int base;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    base = m_ptr;
`else
    base = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (pend[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic step(input bit r, input bit f);
    int g;
    logic [N-1:0] exp_grant;
    @(negedge clk);
    rst      = r;
    in_flush = f;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = pend[i];
      req_tag[i*TW +: TW]   = ptag[i];
      req_val[i*DW +: DW]   = pval[i];
    end
    #1;
    g = (m_busy || f) ? -1 : pick();
    exp_grant = '0;
    if (g >= 0) exp_grant[g] = 1'b1;
    check("grant", {60'd0, req_grant}, {60'd0, exp_grant});
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_ptr = 0; m_cnt = 16'd0; m_tag = INV; m_val = '0;
    end else if (f) begin
      m_busy = 1'b0; m_tag = INV;
    end else if (m_busy) begin
      m_busy = 1'b0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      grant_hist[g]++;
      if (ptag[g] != INV) begin
        m_busy = 1'b1;
        m_cnt  = m_cnt + 16'd1;
        m_tag  = ptag[g];
        m_val  = pval[g];
        exp_q.push_back('{tag: ptag[g], val: pval[g], cnt: m_cnt});
      end
    end
    if (g >= 0) pend[g] = 1'b0;
    started = 1'b1;
  endtask

  // monitor: compare registered outputs after each edge
  always @(posedge clk) begin
    bc_t e;
    #1;
    if (started) begin
      check("strobe", {63'd0, out_CDB_broadcast}, {63'd0, m_busy});
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (out_CDB_broadcast) begin
          check("bc_tag", {59'd0, out_CDB_tag}, {59'd0, e.tag});
          check("bc_val", {32'd0, out_CDB_val}, {32'd0, e.val});
          check("bc_cnt", {48'd0, out_bcast_count}, {48'd0, e.cnt});
        end
      end
      check("tag", {59'd0, out_CDB_tag}, {59'd0, m_tag});
      check("val", {32'd0, out_CDB_val}, {32'd0, m_val});
      check("count", {48'd0, out_bcast_count}, {48'd0, m_cnt});
    end
  end

  task automatic set_req(input int u, input logic [TW-1:0] t, input logic [DW-1:0] v);
    pend[u] = 1'b1; ptag[u] = t; pval[u] = v;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; ptag[i] = '0; pval[i] = '0; grant_hist[i] = 0;
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // single request from unit 2
    set_req(2, 5'd3, 32'h0000_00A5);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // invalid tag consumed silently, unit 2 next
    set_req(1, INV, 32'h1111_1111);
    set_req(2, 5'd7, 32'h2222_2222);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // flush in the accepting cycle, then reset during a broadcast
    set_req(0, 5'd9, 32'hDEAD_BEEF);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // all units valid continuously
    for (int i = 0; i < N; i++) grant_hist[i] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) set_req(i, TW'(i + 1), DW'(32'h100 * (c + 1) + i));
      end
      step(1'b0, 1'b0);
    end
`ifdef CDB_ARB_ROUND_ROBIN_EN
    check("rr_share_u3", 64'(grant_hist[3]), 64'(1));
`else
    check("fixed_starve_u3", 64'(grant_hist[3]), 64'(0));
`endif
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    step(1'b0, 1'b0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(2, 0) == 0) begin
            set_req(i, ($urandom_range(7, 0) == 0) ? INV : TW'($urandom_range(30, 0)), DW'($urandom));
          end
        end else if ($urandom_range(15, 0) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step($urandom_range(99, 0) == 0, $urandom_range(19, 0) == 0);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
